// File: rtl/mips_avalon_arbiter_if.sv
// Bus bundle between the three CPU-side requesters, the arbiter and the
// Avalon memory port. The arbiter uses the master modport (it masters the
// Avalon bus); requesters and memory together use the slave modport.
interface mips_avalon_arbiter_if;
  // instruction-cache line fetch
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_valid;
  // data-cache fetch
  logic        d_req;
  logic [31:0] d_address;
  logic [31:0] d_readdata;
  logic        d_valid;
  // write-buffer drain
  logic        w_req;
  logic [31:0] w_address;
  logic [31:0] w_writedata;
  logic [3:0]  w_byteenable;
  logic        w_urgent;
  logic        w_done;
  // Avalon memory port
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        waitrequest;
  logic [31:0] mem_readdata;
  // current owner for debug
  logic [1:0]  grant;

  modport master (
    input  i_req, i_address, d_req, d_address,
    input  w_req, w_address, w_writedata, w_byteenable, w_urgent,
    input  waitrequest, mem_readdata,
    output i_readdata, i_valid, d_readdata, d_valid, w_done,
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output grant
  );

  modport slave (
    output i_req, i_address, d_req, d_address,
    output w_req, w_address, w_writedata, w_byteenable, w_urgent,
    output waitrequest, mem_readdata,
    input  i_readdata, i_valid, d_readdata, d_valid, w_done,
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  grant
  );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Single-master Avalon arbiter for the MIPS core. Three requesters (I-cache
// fetch, D-cache fetch, write-buffer drain) share one memory port. Fixed
// priority I > D > W, except that W jumps to the top when the write buffer
// is full or W has been kept waiting for STARVE_MAX cycles. A granted
// transaction is latched onto the bus and held until waitrequest drops;
// one IDLE cycle then separates it from the next grant.
module mips_avalon_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_avalon_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    BUS_W = 2'd3
  } state_t;

  localparam logic [7:0] STARVE_LIM = STARVE_MAX[7:0];

  state_t      state, state_next;

  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q,    be_d;
  logic        rd_q,    rd_d;
  logic        wr_q,    wr_d;
  logic [31:0] ird_q,   ird_d;
  logic [31:0] drd_q,   drd_d;
  logic        iv_q,    iv_d;
  logic        dv_q,    dv_d;
  logic        wd_q,    wd_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic        i_elig, d_elig, w_elig, w_promoted;

  // A requester whose completion pulse is showing this cycle still has its
  // old request up; keep it out of arbitration so it is not served twice.
  assign i_elig     = bus.i_req & ~iv_q;
  assign d_elig     = bus.d_req & ~dv_q;
  assign w_elig     = bus.w_req & ~wd_q;
  assign w_promoted = bus.w_urgent | (cnt_q == STARVE_LIM);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Arbitration, bus field capture and completion handling.
  always_comb begin
    state_next = state;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ird_d      = ird_q;
    drd_d      = drd_q;
    iv_d       = 1'b0;
    dv_d       = 1'b0;
    wd_d       = 1'b0;

    case (state)
      IDLE: begin
        if (w_promoted && w_elig) begin
          state_next = BUS_W;
        end else if (i_elig) begin
          state_next = BUS_I;
        end else if (d_elig) begin
          state_next = BUS_D;
        end else if (w_elig) begin
          state_next = BUS_W;
        end

        if (state_next == BUS_I || state_next == BUS_D) begin
          addr_d  = (state_next == BUS_I) ? bus.i_address : bus.d_address;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          be_d    = 4'b1111;
          wdata_d = 32'd0;
        end else if (state_next == BUS_W) begin
          addr_d  = bus.w_address;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          be_d    = bus.w_byteenable;
          wdata_d = bus.w_writedata;
        end
      end

      BUS_I: begin
        if (!bus.waitrequest) begin
          state_next = IDLE;
          rd_d       = 1'b0;
          ird_d      = bus.mem_readdata;
          iv_d       = 1'b1;
        end
      end

      BUS_D: begin
        if (!bus.waitrequest) begin
          state_next = IDLE;
          rd_d       = 1'b0;
          drd_d      = bus.mem_readdata;
          dv_d       = 1'b1;
        end
      end

      BUS_W: begin
        if (!bus.waitrequest) begin
          state_next = IDLE;
          wr_d       = 1'b0;
          wd_d       = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Starvation counter: counts W's waiting cycles, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state == IDLE && state_next == BUS_W) begin
      cnt_d = 8'd0;
    end else if (!bus.w_req) begin
      cnt_d = 8'd0;
    end else if (state != BUS_W && cnt_q != STARVE_LIM) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Registered bus fields, read data, completion pulses and the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ird_q   <= 32'd0;
      drd_q   <= 32'd0;
      iv_q    <= 1'b0;
      dv_q    <= 1'b0;
      wd_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      iv_q    <= iv_d;
      dv_q    <= dv_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_address    = addr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;
  assign bus.i_readdata     = ird_q;
  assign bus.d_readdata     = drd_q;
  assign bus.i_valid        = iv_q;
  assign bus.d_valid        = dv_q;
  assign bus.w_done         = wd_q;
  assign bus.grant          = state;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter with STARVE_MAX=4. A table of per-cycle
// vectors drives the requesters and memory; each vector pushes its expected
// post-edge outputs to a scoreboard queue that is popped after the edge.
// The async-reset abort is a hand-written sequence at the end.
module tb_mips_avalon_arbiter;

  localparam logic [31:0] I_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] D_ADDR = 32'h8000_2000;
  localparam logic [31:0] W_ADDR = 32'h8000_1000;
  localparam logic [31:0] W_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  W_BE   = 4'b0011;

  typedef struct {
    logic        i, d, w, u, wr;
    logic [31:0] rd;
    logic [1:0]  g;
    logic        iv, dv, wd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  g;
    logic        iv, dv, wd;
    logic [31:0] ird, drd;
  } exp_t;

  logic clk;
  logic rst;
  mips_avalon_arbiter_if bus_if();

  mips_avalon_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ird  = 32'd0;
  logic [31:0] exp_drd  = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic i, logic d, logic w, logic u, logic wr,
                              logic [31:0] rd, logic [1:0] g,
                              logic iv, logic dv, logic wd);
    vec_t v;
    v.i = i; v.d = d; v.w = w; v.u = u; v.wr = wr; v.rd = rd;
    v.g = g; v.iv = iv; v.dv = dv; v.wd = wd;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector and push the outputs it should produce after the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    bus_if.i_req        = v.i;
    bus_if.d_req        = v.d;
    bus_if.w_req        = v.w;
    bus_if.w_urgent     = v.u;
    bus_if.waitrequest  = v.wr;
    bus_if.mem_readdata = v.wr ? (32'hDEAD_0000 | 32'(idx)) : v.rd;
    bus_if.d_address    = v.d ? D_ADDR : 32'h0BAD_0000;
    if (v.iv) exp_ird = v.rd;
    if (v.dv) exp_drd = v.rd;
    e.idx = idx; e.g = v.g; e.iv = v.iv; e.dv = v.dv; e.wd = v.wd;
    e.ird = exp_ird; e.drd = exp_drd;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    cmp("grant",      e.idx, 32'(bus_if.grant),      32'(e.g));
    cmp("i_valid",    e.idx, 32'(bus_if.i_valid),    32'(e.iv));
    cmp("d_valid",    e.idx, 32'(bus_if.d_valid),    32'(e.dv));
    cmp("w_done",     e.idx, 32'(bus_if.w_done),     32'(e.wd));
    cmp("mem_read",   e.idx, 32'(bus_if.mem_read),   32'(e.g == 2'd1 || e.g == 2'd2));
    cmp("mem_write",  e.idx, 32'(bus_if.mem_write),  32'(e.g == 2'd3));
    cmp("i_readdata", e.idx, bus_if.i_readdata, e.ird);
    cmp("d_readdata", e.idx, bus_if.d_readdata, e.drd);
    if (e.g != 2'd0) begin
      cmp("mem_address", e.idx, bus_if.mem_address,
          (e.g == 2'd1) ? I_ADDR : (e.g == 2'd2) ? D_ADDR : W_ADDR);
      cmp("mem_byteenable", e.idx, 32'(bus_if.mem_byteenable),
          (e.g == 2'd3) ? 32'(W_BE) : 32'hF);
      cmp("mem_writedata", e.idx, bus_if.mem_writedata,
          (e.g == 2'd3) ? W_DATA : 32'd0);
    end
  endtask

  initial begin
    //            i  d  w  u  wr rd            g  iv dv wd
    // single read, three wait cycles
    vecs.push_back(mk(1,0,0,0,1, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 32'h24020005, 0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));
    // I, D, W together, zero wait
    vecs.push_back(mk(1,1,1,0,0, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 32'h11111111, 0, 1,0,0));
    vecs.push_back(mk(0,1,1,0,0, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 32'h22222222, 0, 0,1,0));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        3, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 32'h33333333, 0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));
    // starvation: W waits 4 cycles behind a long D, then beats I
    vecs.push_back(mk(0,1,1,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(1,1,1,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(1,1,1,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(1,1,1,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 32'h44444444, 0, 0,1,0));
    vecs.push_back(mk(1,0,1,0,1, 32'h0,        3, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 32'h55555555, 0, 0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 32'h66666666, 0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));
    // urgent W wins over I and D
    vecs.push_back(mk(1,1,1,1,1, 32'h0,        3, 0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 32'h77777777, 0, 0,0,1));
    vecs.push_back(mk(1,1,0,0,0, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 32'h88888888, 0, 1,0,0));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 32'h99999999, 0, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));
    // stale I request held through i_valid: D wins the IDLE edge
    vecs.push_back(mk(1,1,0,0,0, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 32'hAAAAAAAA, 0, 1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 32'hBBBBBBBB, 0, 0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 32'h0,        1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 32'hCCCCCCCC, 0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));
    // D drops its request mid-transaction; address stays, pulse still comes
    vecs.push_back(mk(0,1,0,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 32'h0,        2, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 32'hDDDDDDDD, 0, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0, 0,0,0));

    bus_if.i_req = 1'b0; bus_if.d_req = 1'b0; bus_if.w_req = 1'b0;
    bus_if.w_urgent = 1'b0; bus_if.waitrequest = 1'b1;
    bus_if.mem_readdata = 32'd0;
    bus_if.i_address = I_ADDR; bus_if.d_address = D_ADDR;
    bus_if.w_address = W_ADDR; bus_if.w_writedata = W_DATA;
    bus_if.w_byteenable = W_BE;
    rst = 1'b1;

    #1;
    cmp("rst grant",          -1, 32'(bus_if.grant),          32'd0);
    cmp("rst mem_read",       -1, 32'(bus_if.mem_read),       32'd0);
    cmp("rst mem_write",      -1, 32'(bus_if.mem_write),      32'd0);
    cmp("rst mem_address",    -1, bus_if.mem_address,         32'd0);
    cmp("rst mem_writedata",  -1, bus_if.mem_writedata,       32'd0);
    cmp("rst mem_byteenable", -1, 32'(bus_if.mem_byteenable), 32'd0);
    cmp("rst i_readdata",     -1, bus_if.i_readdata,          32'd0);
    cmp("rst d_readdata",     -1, bus_if.d_readdata,          32'd0);
    cmp("rst valids",         -1,
        32'({bus_if.i_valid, bus_if.d_valid, bus_if.w_done}), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      applyStimulus(k, vecs[k]);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // async reset while D is stalled on waitrequest
    @(negedge clk);
    bus_if.d_req = 1'b1; bus_if.d_address = D_ADDR;
    bus_if.waitrequest = 1'b1;
    @(posedge clk);
    #1;
    cmp("abort pre grant",    100, 32'(bus_if.grant),    32'd2);
    cmp("abort pre mem_read", 100, 32'(bus_if.mem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp("abort grant",    101, 32'(bus_if.grant),    32'd0);
    cmp("abort mem_read", 101, 32'(bus_if.mem_read), 32'd0);
    @(negedge clk);
    bus_if.waitrequest = 1'b0;
    bus_if.mem_readdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    cmp("abort d_valid in rst", 102, 32'(bus_if.d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      cmp("after rst grant",   103 + k, 32'(bus_if.grant),   32'd0);
      cmp("after rst d_valid", 103 + k, 32'(bus_if.d_valid), 32'd0);
      cmp("after rst d_readdata", 103 + k, bus_if.d_readdata, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_avalon_arbiter.md
Name: mips_avalon_arbiter

Overview:
- Single-master Avalon arbiter between the CPU-side requesters and the memory bus.
- Three requesters share one Avalon port: instruction-cache line fetch (I), data-cache fetch (D) and write-buffer drain (W).
- Grants one requester at a time and latches its request onto the bus. Holds it until waitrequest drops, returns read data or a write-done pulse, then re-arbitrates.
- Fixed priority I > D > W, with a starvation counter that promotes W.

Parameters:
- STARVE_MAX, 8: consecutive cycles W may be requesting without a grant before it gets top priority; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- i_req  input  1  instruction fetch request; held until i_valid
- i_address  input  32  instruction fetch word address
- i_readdata  output  32  fetched instruction word, registered
- i_valid  output  1  one-cycle pulse, i_readdata valid
- d_req  input  1  data fetch request; held until d_valid
- d_address  input  32  data fetch address
- d_readdata  output  32  fetched data word, registered
- d_valid  output  1  one-cycle pulse, d_readdata valid
- w_req  input  1  write-buffer drain request; held until w_done
- w_address  input  32  write address
- w_writedata  input  32  write data
- w_byteenable  input  4  write byte enables
- w_urgent  input  1  write buffer full; W priority forced to top
- w_done  output  1  one-cycle pulse, write accepted by memory
- mem_address  output  32  Avalon address
- mem_read  output  1  Avalon read
- mem_write  output  1  Avalon write
- mem_writedata  output  32  Avalon write data
- mem_byteenable  output  4  Avalon byte enables
- waitrequest  input  1  Avalon waitrequest
- mem_readdata  input  32  Avalon read data
- grant  output  2  current owner: 0 none, 1 I, 2 D, 3 W (debug/visibility)

Behaviour:
- Reset (async, rst high): state IDLE; all outputs 0, including mem_address, mem_writedata, mem_byteenable, readdata registers and grant; starvation counter 0.
- States: IDLE, BUS_I, BUS_D, BUS_W. grant mirrors state (IDLE=0, BUS_I=1, BUS_D=2, BUS_W=3).
- Arbitration happens at the clock edge leaving IDLE, using the requests sampled that cycle.
- Order when W is not promoted: I, then D, then W.
- W is promoted when w_urgent=1 or the starvation counter equals STARVE_MAX. Promoted order: W, then I, then D.
- On grant, register the bus fields:
  - mem_address from the winner's address input.
  - BUS_I/BUS_D: mem_read=1, mem_byteenable=4'b1111, mem_writedata=0.
  - BUS_W: mem_write=1, mem_writedata=w_writedata, mem_byteenable=w_byteenable.
- Bus outputs are stable for the whole transaction; changes on requester inputs after the grant are ignored.
- In BUS_x, when waitrequest=0 at a clock edge:
  - Drop mem_read/mem_write and go to IDLE.
  - BUS_I: register mem_readdata into i_readdata and assert i_valid for exactly one cycle, in the IDLE cycle. BUS_D works the same with d_readdata/d_valid.
  - BUS_W: assert w_done for exactly one cycle.
- Minimum transaction is 2 cycles: grant edge, then completion edge with waitrequest already low. One IDLE cycle separates transactions.
- In an IDLE cycle where i_valid, d_valid or w_done is high, the just-served requester is excluded from arbitration. This prevents re-granting a stale request; other requesters may win that edge.
- Readdata registers hold their value until the next completion of the same requester.
- Starvation counter:
  - Increments each cycle w_req=1 and state is not BUS_W.
  - Saturates at STARVE_MAX.
  - Clears on the edge that grants W, and whenever w_req=0.
- No requests in IDLE: remain in IDLE with bus outputs deasserted.
- Requester dropping req mid-transaction: the transaction still completes, and the valid/done pulse is still issued.
- Reset mid-transaction: abort immediately; mem_read/mem_write drop asynchronously; no valid/done pulse is issued.

Test Plan:
- Single read: i_req=1, i_address=0xBFC00000, waitrequest low after 3 cycles, mem_readdata=0x24020005 -> mem_read high for 3 cycles at address 0xBFC00000, byteenable 1111; i_valid pulses once with i_readdata=0x24020005; grant 1->0.
- Simultaneous I, D, W requests, waitrequest always 0 -> serviced in order I, D, W, each taking 2 cycles plus 1 IDLE cycle; w_done on the third completion.
- Starvation: STARVE_MAX=4, i_req held continuously, w_req=1 -> after 4 waiting cycles W is granted ahead of I; mem_write=1 with w_byteenable=4'b0011 and w_writedata=0xDEADBEEF at w_address; counter returns to 0.
- w_urgent=1 together with i_req and d_req from IDLE -> BUS_W is granted first.
- Async reset asserted during BUS_D with waitrequest=1 -> mem_read=0 and grant=0 before the next clk edge; d_valid never pulses; after release, state is IDLE.
- Stale request: i_req kept high through i_valid with d_req=1 -> D is granted in the IDLE cycle rather than I; I is re-granted only after D completes.
